// File: rtl/ht_engine_dispatcher.sv
// ht_engine_dispatcher: accepts one hash-table task at a time and routes it by
// opcode to the search, insert or delete engine. While a task is in flight,
// that engine has exclusive use of the data-RAM ports. Its result comes back on
// a single output stream.
// Optional build macro HT_DISPATCH_STATS_EN adds per-engine completion counters.

package ht_pkg;

    localparam int KEY_WIDTH        = 16;
    localparam int VALUE_WIDTH      = 16;
    localparam int TABLE_ADDR_WIDTH = 8;
    localparam int ENG_CNT          = 3;

    typedef enum logic [1:0] {
        OP_SEARCH = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_NOOP   = 2'd3
    } ht_opcode_t;

    typedef enum logic [2:0] {
        SEARCH_FOUND                     = 3'd0,
        SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
        INSERT_SUCCESS                   = 3'd2,
        INSERT_SUCCESS_SAME_KEY          = 3'd3,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
        DELETE_SUCCESS                   = 3'd5,
        DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6
    } ht_rescode_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        ht_opcode_t             opcode;
    } ht_command_t;

    typedef struct packed {
        ht_command_t                 cmd;
        logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
        logic                        head_ptr_val;
    } ht_pdata_t;

    typedef struct packed {
        ht_command_t                 cmd;
        ht_rescode_t                 rescode;
        logic [TABLE_ADDR_WIDTH-1:0] bucket;
    } ht_result_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]        key;
        logic [VALUE_WIDTH-1:0]      value;
        logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
        logic                        next_ptr_val;
    } ram_data_t;

endpackage

module ht_engine_dispatcher
    import ht_pkg::*;
#(
    parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  ht_pdata_t                        task_i,
    input  logic                             task_valid_i,
    output logic                             task_ready_o,

    output ht_pdata_t                        eng_task_o,
    output logic [ENG_CNT-1:0]               eng_task_valid_o,
    input  logic [ENG_CNT-1:0]               eng_task_ready_i,

    input  logic [ENG_CNT-1:0][A_WIDTH-1:0]  eng_rd_addr_i,
    input  logic [ENG_CNT-1:0]               eng_rd_en_i,
    input  logic [ENG_CNT-1:0][A_WIDTH-1:0]  eng_wr_addr_i,
    input  ram_data_t [ENG_CNT-1:0]          eng_wr_data_i,
    input  logic [ENG_CNT-1:0]               eng_wr_en_i,

    output logic [A_WIDTH-1:0]               rd_addr_o,
    output logic                             rd_en_o,
    output logic [A_WIDTH-1:0]               wr_addr_o,
    output ram_data_t                        wr_data_o,
    output logic                             wr_en_o,

    input  ht_result_t [ENG_CNT-1:0]         eng_result_i,
    input  logic [ENG_CNT-1:0]               eng_result_valid_i,
    output logic [ENG_CNT-1:0]               eng_result_ready_o,

    output ht_result_t                       result_o,
    output logic                             result_valid_o,
    input  logic                             result_ready_i,

`ifdef HT_DISPATCH_STATS_EN
    output logic [31:0]                      search_cnt_o,
    output logic [31:0]                      insert_cnt_o,
    output logic [31:0]                      delete_cnt_o,
`endif

    output logic [15:0]                      drop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        DISPATCH_S = 2'd1,
        WAIT_RES_S = 2'd2,
        OUT_RES_S  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    ht_pdata_t   task_q, task_d;
    ht_result_t  result_q, result_d;
    logic [15:0] drop_q, drop_d;
    logic        res_take;
    logic        ram_sel;
    logic [1:0]  ram_src;

    assign eng_task_o = task_q;
    assign result_o   = result_q;
    assign drop_cnt_o = drop_q;

    // The selected engine's result is captured only while we wait for it.
    assign res_take = (state_q == WAIT_RES_S) && eng_result_valid_i[idx_q];

    // State, engine index, task/result registers and drop counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE_S;
            idx_q    <= 2'd0;
            task_q   <= '0;
            result_q <= '0;
            drop_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            task_q   <= task_d;
            result_q <= result_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state decode and per-state handshake outputs.
    always_comb begin
        state_d            = state_q;
        idx_d              = idx_q;
        task_d             = task_q;
        result_d           = result_q;
        drop_d             = drop_q;
        task_ready_o       = 1'b0;
        eng_task_valid_o   = '0;
        eng_result_ready_o = '0;
        result_valid_o     = 1'b0;

        case (state_q)
            IDLE_S: begin
                // Ready is withheld while reset is asserted so that an upstream
                // valid never looks accepted during reset.
                task_ready_o = !rst_i;
                if (task_valid_i && !rst_i) begin
                    case (task_i.cmd.opcode)
                        OP_SEARCH: begin
                            idx_d   = 2'd0;
                            task_d  = task_i;
                            state_d = DISPATCH_S;
                        end
                        OP_INSERT: begin
                            idx_d   = 2'd1;
                            task_d  = task_i;
                            state_d = DISPATCH_S;
                        end
                        OP_DELETE: begin
                            idx_d   = 2'd2;
                            task_d  = task_i;
                            state_d = DISPATCH_S;
                        end
                        default: begin
                            if (drop_q != 16'hFFFF) begin
                                drop_d = drop_q + 16'd1;
                            end
                        end
                    endcase
                end
            end
            DISPATCH_S: begin
                eng_task_valid_o[idx_q] = 1'b1;
                if (eng_task_ready_i[idx_q]) begin
                    state_d = WAIT_RES_S;
                end
            end
            WAIT_RES_S: begin
                eng_result_ready_o[idx_q] = 1'b1;
                if (res_take) begin
                    result_d = eng_result_i[idx_q];
                    state_d  = OUT_RES_S;
                end
            end
            OUT_RES_S: begin
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    state_d = IDLE_S;
                end
            end
            default: begin
                state_d = IDLE_S;
            end
        endcase
    end

    // RAM mux: zero-latency path from the active engine while it owns the RAM.
    always_comb begin
        ram_sel   = (state_q == DISPATCH_S) || (state_q == WAIT_RES_S);
        ram_src   = ram_sel ? idx_q : 2'd0;
        rd_addr_o = eng_rd_addr_i[ram_src];
        wr_addr_o = eng_wr_addr_i[ram_src];
        wr_data_o = eng_wr_data_i[ram_src];
        rd_en_o   = ram_sel && eng_rd_en_i[ram_src];
        wr_en_o   = ram_sel && eng_wr_en_i[ram_src];
    end

`ifdef HT_DISPATCH_STATS_EN
    logic [31:0] search_cnt_q, insert_cnt_q, delete_cnt_q;

    assign search_cnt_o = search_cnt_q;
    assign insert_cnt_o = insert_cnt_q;
    assign delete_cnt_o = delete_cnt_q;

    // Per-engine completion counters, bumped alongside the result register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            search_cnt_q <= 32'd0;
            insert_cnt_q <= 32'd0;
            delete_cnt_q <= 32'd0;
        end else if (res_take) begin
            case (idx_q)
                2'd0:    search_cnt_q <= search_cnt_q + 32'd1;
                2'd1:    insert_cnt_q <= insert_cnt_q + 32'd1;
                2'd2:    delete_cnt_q <= delete_cnt_q + 32'd1;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ht_engine_dispatcher.sv
// Directed bench for ht_engine_dispatcher. Stats counters are checked when
// HT_DISPATCH_STATS_EN is defined.

module tb_ht_engine_dispatcher;
    import ht_pkg::*;

    localparam int AW = TABLE_ADDR_WIDTH;

    logic                          clk = 1'b0;
    logic                          rst_i;
    ht_pdata_t                     task_i;
    logic                          task_valid_i;
    logic                          task_ready_o;
    ht_pdata_t                     eng_task_o;
    logic [ENG_CNT-1:0]            eng_task_valid_o;
    logic [ENG_CNT-1:0]            eng_task_ready_i;
    logic [ENG_CNT-1:0][AW-1:0]    eng_rd_addr_i;
    logic [ENG_CNT-1:0]            eng_rd_en_i;
    logic [ENG_CNT-1:0][AW-1:0]    eng_wr_addr_i;
    ram_data_t [ENG_CNT-1:0]       eng_wr_data_i;
    logic [ENG_CNT-1:0]            eng_wr_en_i;
    logic [AW-1:0]                 rd_addr_o;
    logic                          rd_en_o;
    logic [AW-1:0]                 wr_addr_o;
    ram_data_t                     wr_data_o;
    logic                          wr_en_o;
    ht_result_t [ENG_CNT-1:0]      eng_result_i;
    logic [ENG_CNT-1:0]            eng_result_valid_i;
    logic [ENG_CNT-1:0]            eng_result_ready_o;
    ht_result_t                    result_o;
    logic                          result_valid_o;
    logic                          result_ready_i;
    logic [15:0]                   drop_cnt_o;
`ifdef HT_DISPATCH_STATS_EN
    logic [31:0]                   search_cnt_o, insert_cnt_o, delete_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ht_engine_dispatcher #(.A_WIDTH(AW)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .task_i             (task_i),
        .task_valid_i       (task_valid_i),
        .task_ready_o       (task_ready_o),
        .eng_task_o         (eng_task_o),
        .eng_task_valid_o   (eng_task_valid_o),
        .eng_task_ready_i   (eng_task_ready_i),
        .eng_rd_addr_i      (eng_rd_addr_i),
        .eng_rd_en_i        (eng_rd_en_i),
        .eng_wr_addr_i      (eng_wr_addr_i),
        .eng_wr_data_i      (eng_wr_data_i),
        .eng_wr_en_i        (eng_wr_en_i),
        .rd_addr_o          (rd_addr_o),
        .rd_en_o            (rd_en_o),
        .wr_addr_o          (wr_addr_o),
        .wr_data_o          (wr_data_o),
        .wr_en_o            (wr_en_o),
        .eng_result_i       (eng_result_i),
        .eng_result_valid_i (eng_result_valid_i),
        .eng_result_ready_o (eng_result_ready_o),
        .result_o           (result_o),
        .result_valid_o     (result_valid_o),
        .result_ready_i     (result_ready_i),
`ifdef HT_DISPATCH_STATS_EN
        .search_cnt_o       (search_cnt_o),
        .insert_cnt_o       (insert_cnt_o),
        .delete_cnt_o       (delete_cnt_o),
`endif
        .drop_cnt_o         (drop_cnt_o)
    );

    function automatic ht_pdata_t mk_task(ht_opcode_t op, logic [15:0] key);
        ht_pdata_t t;
        t.cmd.key      = key;
        t.cmd.value    = key ^ 16'hA5A5;
        t.cmd.opcode   = op;
        t.head_ptr     = key[7:0];
        t.head_ptr_val = 1'b1;
        return t;
    endfunction

    function automatic ht_result_t mk_res(ht_pdata_t t, ht_rescode_t rc, logic [AW-1:0] bkt);
        ht_result_t r;
        r.cmd     = t.cmd;
        r.rescode = rc;
        r.bucket  = bkt;
        return r;
    endfunction

    // Distinct RAM-port pattern per engine e and seed s.
    task automatic set_ram(input int s);
        for (int e = 0; e < ENG_CNT; e++) begin
            eng_rd_addr_i[e]              = AW'(s * 8 + e);
            eng_wr_addr_i[e]              = AW'(200 - s * 8 - e);
            eng_rd_en_i[e]                = ((s + e) % 2) == 1;
            eng_wr_en_i[e]                = ((s + e) % 2) == 0;
            eng_wr_data_i[e].key          = 16'(s * 256 + e);
            eng_wr_data_i[e].value        = 16'(e * 100 + s);
            eng_wr_data_i[e].next_ptr     = AW'(s + e);
            eng_wr_data_i[e].next_ptr_val = (e == 2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i        = 1'b1;
        task_valid_i = 1'b1;
        task_i       = mk_task(OP_SEARCH, 16'h0011);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (task_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_during got=%0b exp=0", task_ready_o); end
        checks++; if (eng_task_valid_o !== 3'b000) begin errors++; $display("FAIL rst_eng_valid_during got=%0b exp=000", eng_task_valid_o); end
        task_valid_i = 1'b0;
        rst_i        = 1'b0;
        #1;
        checks++; if (task_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%0b exp=1", task_ready_o); end
        checks++; if ({rd_en_o, wr_en_o, result_valid_o} !== 3'b000) begin errors++; $display("FAIL rst_enables got=%0b exp=000", {rd_en_o, wr_en_o, result_valid_o}); end
        checks++; if (eng_result_ready_o !== 3'b000) begin errors++; $display("FAIL rst_res_ready got=%0b exp=000", eng_result_ready_o); end
        checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt_o); end
        checks++; if (result_o !== '0) begin errors++; $display("FAIL rst_result got=%0h exp=0", result_o); end
        checks++; if (eng_task_o !== '0) begin errors++; $display("FAIL rst_eng_task got=%0h exp=0", eng_task_o); end
    endtask

    task automatic test_delete();
        ht_pdata_t  t;
        ht_result_t r;
        ram_data_t  wd;
        t = mk_task(OP_DELETE, 16'h1234);
        r = mk_res(t, DELETE_SUCCESS, 8'h34);
        tick();
        task_i = t; task_valid_i = 1'b1; eng_task_ready_i = 3'b111;
        #1;
        checks++; if (task_ready_o !== 1'b1) begin errors++; $display("FAIL del_ready got=%0b exp=1", task_ready_o); end
        for (int c = 0; c < 7; c++) begin
            tick();
            task_valid_i = 1'b0;
            set_ram(c + 1);
            eng_result_i[0] = mk_res(t, SEARCH_FOUND, 8'h01);
            eng_result_i[1] = mk_res(t, INSERT_SUCCESS, 8'h02);
            eng_result_i[2] = r;
            eng_result_valid_i = (c == 6) ? 3'b100 : ((c == 3) ? 3'b011 : 3'b000);
            #1;
            if (c == 0) begin
                checks++; if (eng_task_valid_o !== 3'b100) begin errors++; $display("FAIL del_dispatch got=%0b exp=100", eng_task_valid_o); end
                checks++; if (eng_task_o !== t) begin errors++; $display("FAIL del_eng_task got=%0h exp=%0h", eng_task_o, t); end
            end else begin
                checks++; if (eng_task_valid_o !== 3'b000) begin errors++; $display("FAIL del_valid_once c=%0d got=%0b exp=000", c, eng_task_valid_o); end
                checks++; if (eng_result_ready_o !== 3'b100) begin errors++; $display("FAIL del_res_ready c=%0d got=%0b exp=100", c, eng_result_ready_o); end
                checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL del_early_result c=%0d got=%0b exp=0", c, result_valid_o); end
            end
            wd.key = 16'((c + 1) * 256 + 2); wd.value = 16'(200 + c + 1);
            wd.next_ptr = AW'(c + 3); wd.next_ptr_val = 1'b1;
            checks++; if (rd_addr_o !== AW'((c + 1) * 8 + 2)) begin errors++; $display("FAIL del_rd_addr c=%0d got=%0h exp=%0h", c, rd_addr_o, AW'((c + 1) * 8 + 2)); end
            checks++; if (wr_addr_o !== AW'(200 - (c + 1) * 8 - 2)) begin errors++; $display("FAIL del_wr_addr c=%0d got=%0h exp=%0h", c, wr_addr_o, AW'(200 - (c + 1) * 8 - 2)); end
            checks++; if (rd_en_o !== ((c + 3) % 2 == 1)) begin errors++; $display("FAIL del_rd_en c=%0d got=%0b", c, rd_en_o); end
            checks++; if (wr_en_o !== ((c + 3) % 2 == 0)) begin errors++; $display("FAIL del_wr_en c=%0d got=%0b", c, wr_en_o); end
            checks++; if (wr_data_o !== wd) begin errors++; $display("FAIL del_wr_data c=%0d got=%0h exp=%0h", c, wr_data_o, wd); end
        end
        tick();
        eng_result_valid_i = 3'b000; result_ready_i = 1'b1;
        #1;
        checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL del_result_valid got=%0b exp=1", result_valid_o); end
        checks++; if (result_o.rescode !== DELETE_SUCCESS) begin errors++; $display("FAIL del_rescode got=%0d exp=%0d", result_o.rescode, DELETE_SUCCESS); end
        checks++; if (result_o !== r) begin errors++; $display("FAIL del_result got=%0h exp=%0h", result_o, r); end
        checks++; if ({rd_en_o, wr_en_o} !== 2'b00) begin errors++; $display("FAIL del_out_ram_en got=%0b exp=00", {rd_en_o, wr_en_o}); end
        checks++; if (eng_result_ready_o !== 3'b000) begin errors++; $display("FAIL del_out_res_ready got=%0b exp=000", eng_result_ready_o); end
        tick();
        checks++; if ({task_ready_o, result_valid_o} !== 2'b10) begin errors++; $display("FAIL del_back_idle got=%0b exp=10", {task_ready_o, result_valid_o}); end
    endtask

    task automatic test_ram_isolation();
        ht_pdata_t  t;
        ht_result_t r;
        t = mk_task(OP_SEARCH, 16'h0042);
        r = mk_res(t, SEARCH_FOUND, 8'h42);
        eng_rd_addr_i[0] = 8'h3C; eng_rd_addr_i[1] = 8'h55; eng_rd_addr_i[2] = 8'h66;
        eng_wr_addr_i[1] = 8'hAA;
        eng_rd_en_i = 3'b001; eng_wr_en_i = 3'b010;
        eng_result_i[0] = r;
        eng_result_i[1] = mk_res(t, INSERT_SUCCESS, 8'h99);
        task_i = t; task_valid_i = 1'b1;
        tick();
        task_valid_i = 1'b0;
        #1;
        checks++; if (eng_task_valid_o !== 3'b001) begin errors++; $display("FAIL iso_dispatch got=%0b exp=001", eng_task_valid_o); end
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL iso_wr_en_disp got=%0b exp=0", wr_en_o); end
        checks++; if ({rd_en_o, rd_addr_o} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL iso_rd_disp got=%0h exp=13c", {rd_en_o, rd_addr_o}); end
        tick();
        eng_result_valid_i = 3'b010;
        #1;
        checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL iso_wr_en_wait got=%0b exp=0", wr_en_o); end
        checks++; if (rd_addr_o !== 8'h3C) begin errors++; $display("FAIL iso_rd_addr_wait got=%0h exp=3c", rd_addr_o); end
        checks++; if (eng_result_ready_o !== 3'b001) begin errors++; $display("FAIL iso_res_ready got=%0b exp=001", eng_result_ready_o); end
        tick();
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL iso_foreign_result got=%0b exp=0", result_valid_o); end
        eng_result_valid_i = 3'b001;
        tick();
        eng_result_valid_i = 3'b000;
        checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL iso_result_valid got=%0b exp=1", result_valid_o); end
        checks++; if (result_o !== r) begin errors++; $display("FAIL iso_result got=%0h exp=%0h", result_o, r); end
        tick();
        eng_wr_en_i = 3'b000; eng_rd_en_i = 3'b000;
    endtask

    task automatic test_drop();
        task_i = mk_task(OP_NOOP, 16'h0BAD);
        task_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (task_ready_o !== 1'b1) begin errors++; $display("FAIL drop_ready i=%0d got=%0b exp=1", i, task_ready_o); end
            checks++; if (eng_task_valid_o !== 3'b000) begin errors++; $display("FAIL drop_dispatch i=%0d got=%0b exp=000", i, eng_task_valid_o); end
            tick();
        end
        task_valid_i = 1'b0;
        #1;
        checks++; if (drop_cnt_o !== 16'd3) begin errors++; $display("FAIL drop_cnt got=%0d exp=3", drop_cnt_o); end
        checks++; if ({task_ready_o, result_valid_o, eng_task_valid_o} !== 5'b10000) begin errors++; $display("FAIL drop_state got=%0b exp=10000", {task_ready_o, result_valid_o, eng_task_valid_o}); end
    endtask

    task automatic test_backpressure();
        ht_pdata_t  t, t2;
        ht_result_t r, r2;
        t  = mk_task(OP_INSERT, 16'h0777);
        t2 = mk_task(OP_SEARCH, 16'h0888);
        r  = mk_res(t, INSERT_SUCCESS, 8'h77);
        r2 = mk_res(t2, SEARCH_NOT_SUCCESS_NO_ENTRY, 8'h88);
        result_ready_i = 1'b0;
        task_i = t; task_valid_i = 1'b1;
        tick();
        task_i = t2;
        #1;
        checks++; if (task_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_disp got=%0b exp=0", task_ready_o); end
        checks++; if (eng_task_valid_o !== 3'b010) begin errors++; $display("FAIL bp_dispatch got=%0b exp=010", eng_task_valid_o); end
        tick();
        eng_result_i[1] = r; eng_result_valid_i = 3'b010;
        tick();
        eng_result_valid_i = 3'b000;
        eng_result_i[1] = mk_res(t2, INSERT_NOT_SUCCESS_TABLE_IS_FULL, 8'h00);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({result_valid_o, task_ready_o} !== 2'b10) begin errors++; $display("FAIL bp_hold i=%0d got=%0b exp=10", i, {result_valid_o, task_ready_o}); end
            checks++; if (result_o !== r) begin errors++; $display("FAIL bp_stable i=%0d got=%0h exp=%0h", i, result_o, r); end
            tick();
        end
        result_ready_i = 1'b1;
        #1;
        checks++; if ({result_valid_o, task_ready_o} !== 2'b10) begin errors++; $display("FAIL bp_release got=%0b exp=10", {result_valid_o, task_ready_o}); end
        tick();
        checks++; if ({task_ready_o, eng_task_valid_o} !== 4'b1000) begin errors++; $display("FAIL bp_idle got=%0b exp=1000", {task_ready_o, eng_task_valid_o}); end
        tick();
        task_valid_i = 1'b0;
        #1;
        checks++; if (eng_task_valid_o !== 3'b001) begin errors++; $display("FAIL bp_next_dispatch got=%0b exp=001", eng_task_valid_o); end
        checks++; if (eng_task_o !== t2) begin errors++; $display("FAIL bp_next_task got=%0h exp=%0h", eng_task_o, t2); end
        tick();
        eng_result_i[0] = r2; eng_result_valid_i = 3'b001;
        tick();
        eng_result_valid_i = 3'b000;
        checks++; if (result_o !== r2) begin errors++; $display("FAIL bp_next_result got=%0h exp=%0h", result_o, r2); end
        tick();
    endtask

`ifdef HT_DISPATCH_STATS_EN
    task automatic test_stats();
        ht_pdata_t t;
        result_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t = mk_task(OP_DELETE, 16'(16'h0500 + i));
            task_i = t; task_valid_i = 1'b1;
            tick();
            task_valid_i = 1'b0;
            tick();
            eng_result_i[2] = mk_res(t, DELETE_NOT_SUCCESS_NO_ENTRY, 8'h05);
            eng_result_valid_i = 3'b100;
            tick();
            eng_result_valid_i = 3'b000;
            tick();
        end
        checks++; if (search_cnt_o !== 32'd2) begin errors++; $display("FAIL stats_search got=%0d exp=2", search_cnt_o); end
        checks++; if (insert_cnt_o !== 32'd1) begin errors++; $display("FAIL stats_insert got=%0d exp=1", insert_cnt_o); end
        checks++; if (delete_cnt_o !== 32'd4) begin errors++; $display("FAIL stats_delete got=%0d exp=4", delete_cnt_o); end
    endtask
`endif

    task automatic test_reset_mid_task();
        task_i = mk_task(OP_INSERT, 16'h0321); task_valid_i = 1'b1;
        tick();
        task_valid_i = 1'b0;
        tick();
        checks++; if (eng_result_ready_o !== 3'b010) begin errors++; $display("FAIL mid_wait got=%0b exp=010", eng_result_ready_o); end
        rst_i = 1'b1;
        #1;
        checks++; if ({task_ready_o, eng_result_ready_o, eng_task_valid_o} !== 7'b0) begin errors++; $display("FAIL mid_rst_outputs got=%0b exp=0", {task_ready_o, eng_result_ready_o, eng_task_valid_o}); end
        checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_rst_drop got=%0d exp=0", drop_cnt_o); end
        checks++; if (result_o !== '0) begin errors++; $display("FAIL mid_rst_result got=%0h exp=0", result_o); end
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if ({task_ready_o, result_valid_o} !== 2'b10) begin errors++; $display("FAIL mid_after got=%0b exp=10", {task_ready_o, result_valid_o}); end
    endtask

    initial begin
        rst_i = 1'b1;
        task_i = '0; task_valid_i = 1'b0;
        eng_task_ready_i = 3'b111;
        eng_rd_addr_i = '0; eng_rd_en_i = '0; eng_wr_addr_i = '0;
        eng_wr_data_i = '0; eng_wr_en_i = '0;
        eng_result_i = '0; eng_result_valid_i = '0;
        result_ready_i = 1'b1;
        test_reset();
        test_delete();
        test_ram_isolation();
        test_drop();
        test_backpressure();
`ifdef HT_DISPATCH_STATS_EN
        test_stats();
`endif
        test_reset_mid_task();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
